// File: rtl/regbank_pkg.sv
// regbank_pkg
//   Shared types and default widths for the register bank write-back path.
//   DEF_ADDR_W / DEF_DATA_W : default register index and data widths
//   wb_entry_t              : one queued write {rd, data} at the default widths
//   grant_t                 : which producer was granted the write port
package regbank_pkg;

  localparam int DEF_ADDR_W = 4;
  localparam int DEF_DATA_W = 32;

  typedef struct packed {
    logic [DEF_ADDR_W-1:0] rd;
    logic [DEF_DATA_W-1:0] data;
  } wb_entry_t;

  typedef enum logic {
    GNT_ALU = 1'b0,
    GNT_MEM = 1'b1
  } grant_t;

endpackage

// File: rtl/wb_fifo.sv
// wb_fifo
//   Synchronous FIFO of write-back entries. Full/empty come from read/write
//   pointers carrying one extra wrap bit. The raw storage array and a
//   per-slot occupancy mask are exported so the parent can build its
//   pending-write mask without a second copy of the queue.
// Ports
//   clk, rst_n    : clock, synchronous active-low reset (pointers only)
//   push          : write push_entry at the tail (caller guarantees !full)
//   push_entry    : entry to enqueue
//   pop           : drop the head entry (caller guarantees !empty)
//   head          : current head entry
//   full, empty   : occupancy flags
//   entries       : raw storage slots
//   entry_valid   : bit i set when slot i holds a queued entry
module wb_fifo
  import regbank_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = wb_entry_t
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  entry_t           push_entry,
  input  logic             pop,
  output entry_t           head,
  output logic             full,
  output logic             empty,
  output entry_t           entries [DEPTH],
  output logic [DEPTH-1:0] entry_valid
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W:0] wr_ptr;
  logic [PTR_W:0] rd_ptr;
  logic [PTR_W:0] count;
  entry_t         mem [DEPTH];

  // NOTE: sequential state is assigned with <= so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: storage has no reset; occupancy is defined purely by the pointers,
  // so stale slot contents are never observed as valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[PTR_W-1:0]] <= push_entry;
  end

  assign count   = wr_ptr - rd_ptr;
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                   (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign head    = mem[rd_ptr[PTR_W-1:0]];
  assign entries = mem;

  // A slot is live when its distance from the read pointer is below the
  // current occupancy.
  // NOTE: always_comb outputs get a default first so no path leaves them
  // unassigned and infers a latch.
  always_comb begin
    entry_valid = '0;
    for (int i = 0; i < DEPTH; i++) begin
      logic [PTR_W-1:0] offset;
      offset         = PTR_W'(i) - rd_ptr[PTR_W-1:0];
      entry_valid[i] = ({1'b0, offset} < count);
    end
  end

endmodule

// File: rtl/regbank_writeback.sv
// regbank_writeback
//   Write-back initiator for the register bank. ALU and load results arrive
//   over valid/ready, are queued per source, and are round-robined onto the
//   single bank write port. A pending mask lists every register with a write
//   queued or currently on the port.
//   Optional feature macro: WB_BYPASS_EN adds two combinational bypass read
//   ports covering the cycle in which the bank has not yet captured a write.
// Ports
//   clk, rst_n                    : clock, synchronous active-low reset
//   alu_valid/ready/rd/data       : ALU result handshake and payload
//   mem_valid/ready/rd/data       : load result handshake and payload
//   wb_hold                       : freeze arbitration (no pops while high)
//   reg_write/write_reg/write_data: registered bank write port
//   pending                       : per-register in-flight write mask
//   byp_reg1/2, byp_hit1/2, byp_data1/2 : bypass ports (WB_BYPASS_EN only)
module regbank_writeback
  import regbank_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 alu_valid,
  output logic                 alu_ready,
  input  logic [ADDR_W-1:0]    alu_rd,
  input  logic [DATA_W-1:0]    alu_data,
  input  logic                 mem_valid,
  output logic                 mem_ready,
  input  logic [ADDR_W-1:0]    mem_rd,
  input  logic [DATA_W-1:0]    mem_data,
  input  logic                 wb_hold,
  output logic                 reg_write,
  output logic [ADDR_W-1:0]    write_reg,
  output logic [DATA_W-1:0]    write_data,
  output logic [2**ADDR_W-1:0] pending
`ifdef WB_BYPASS_EN
  ,
  input  logic [ADDR_W-1:0]    byp_reg1,
  input  logic [ADDR_W-1:0]    byp_reg2,
  output logic                 byp_hit1,
  output logic                 byp_hit2,
  output logic [DATA_W-1:0]    byp_data1,
  output logic [DATA_W-1:0]    byp_data2
`endif
);

  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t                alu_in, mem_in;
  entry_t                alu_head, mem_head;
  entry_t                alu_entries [FIFO_DEPTH];
  entry_t                mem_entries [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] alu_live, mem_live;
  logic                  alu_full, alu_empty, mem_full, mem_empty;
  logic                  alu_push, mem_push, alu_pop, mem_pop;
  grant_t                last_grant;

  // Ready reflects occupancy only; a full FIFO stays not-ready even in the
  // cycle it is popped.
  assign alu_ready = !alu_full;
  assign mem_ready = !mem_full;

  // Writes to r0 complete the handshake but are dropped here.
  assign alu_push = alu_valid && alu_ready && (alu_rd != '0);
  assign mem_push = mem_valid && mem_ready && (mem_rd != '0);

  assign alu_in = '{rd: alu_rd, data: alu_data};
  assign mem_in = '{rd: mem_rd, data: mem_data};

  wb_fifo #(.DEPTH(FIFO_DEPTH), .entry_t(entry_t)) u_alu_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (alu_push),
    .push_entry (alu_in),
    .pop        (alu_pop),
    .head       (alu_head),
    .full       (alu_full),
    .empty      (alu_empty),
    .entries    (alu_entries),
    .entry_valid(alu_live)
  );

  wb_fifo #(.DEPTH(FIFO_DEPTH), .entry_t(entry_t)) u_mem_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (mem_push),
    .push_entry (mem_in),
    .pop        (mem_pop),
    .head       (mem_head),
    .full       (mem_full),
    .empty      (mem_empty),
    .entries    (mem_entries),
    .entry_valid(mem_live)
  );

  // Round-robin: on a tie the source not granted last time wins.
  always_comb begin
    alu_pop = 1'b0;
    mem_pop = 1'b0;
    if (!wb_hold) begin
      if (!alu_empty && !mem_empty) begin
        if (last_grant == GNT_MEM) alu_pop = 1'b1;
        else                       mem_pop = 1'b1;
      end else if (!alu_empty) begin
        alu_pop = 1'b1;
      end else if (!mem_empty) begin
        mem_pop = 1'b1;
      end
    end
  end

  // Output register: one-cycle write strobe, index/data hold between writes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      reg_write  <= 1'b0;
      write_reg  <= '0;
      write_data <= '0;
      last_grant <= GNT_MEM;
    end else begin
      reg_write <= alu_pop || mem_pop;
      if (alu_pop) begin
        write_reg  <= alu_head.rd;
        write_data <= alu_head.data;
        last_grant <= GNT_ALU;
      end else if (mem_pop) begin
        write_reg  <= mem_head.rd;
        write_data <= mem_head.data;
        last_grant <= GNT_MEM;
      end
    end
  end

  always_comb begin
    pending = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (alu_live[i]) pending[alu_entries[i].rd] = 1'b1;
      if (mem_live[i]) pending[mem_entries[i].rd] = 1'b1;
    end
    if (reg_write) pending[write_reg] = 1'b1;
    pending[0] = 1'b0;
  end

`ifdef WB_BYPASS_EN
  assign byp_hit1  = reg_write && (write_reg == byp_reg1) && (byp_reg1 != '0);
  assign byp_hit2  = reg_write && (write_reg == byp_reg2) && (byp_reg2 != '0);
  assign byp_data1 = byp_hit1 ? write_data : '0;
  assign byp_data2 = byp_hit2 ? write_data : '0;
`endif

endmodule
